pcg_permute_pipe: RTL
=====================

// Module: pcg_permute_pipe
// PURPOSE
//  Parametrised PCG output-permutation stage: maps a STATE_W-bit generator state to an OUT_W-bit random word.
//  Sits between the LCG/MCG state core and the output FIFO / bus interface.
//  Run-time selectable permutation: XSH-RR, XSH-RS or plain truncation.
//  2-stage pipeline with valid/ready backpressure and an output transfer counter.
// PARAMETERS
//  STATE_W  64  generator state width; must equal 2*OUT_W
//  OUT_W    32  output word width; power of two, >= 8
//  ROT_W     5  rotate-amount width for XSH-RR; = log2(OUT_W)
//  RR_XS    18  XSH-RR xorshift distance
//  RS_OPW    3  XSH-RS op-bit count (taken from state MSBs)
//  RS_XS    22  XSH-RS xorshift distance; also base shift
//  CNT_W    32  width of out_count
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous, active-low reset
//  flush      in   1        synchronous clear of pipeline contents
//  in_valid   in   1        state word valid
//  in_ready   out  1        block accepts state word this cycle
//  in_state   in   STATE_W  generator state
//  in_mode    in   2        00=XSH-RR 01=XSH-RS 10=TRUNC 11=reserved (treated as TRUNC)
//  out_valid  out  1        permuted word valid
//  out_ready  in   1        downstream accepts word
//  out_data   out  OUT_W    permuted word
//  out_count  out  CNT_W    number of completed output transfers, wraps
// BEHAVIOUR
//  Reset (rst=0, async): s1_valid, out_valid=0; out_data=0; out_count=0; all stage regs=0. in_ready=1 one cycle after release.
//  Transfer rules: input transfer when in_valid&&in_ready. Output transfer when out_valid&&out_ready.
//  Stall rules: out_valid/out_data hold stable while out_valid&&!out_ready.
//  No combinational path from in_valid to out_valid. No combinational path from in_state to out_data.
//  Stage 1 (on input transfer): capture mode and the computed shift/rotate amount.
//   RR: x1 = s ^ (s >> RR_XS); amt = s[STATE_W-1 -: ROT_W].
//   RS: x1 = s ^ (s >> RS_XS); amt = RS_XS + s[STATE_W-1 -: RS_OPW].
//   TRUNC: x1 = s; amt = 0.
//  Stage 2 (output register):
//   RR: t = (x1 >> (STATE_W-OUT_W-ROT_W))[OUT_W-1:0]; out_data = rotr(t, amt). amt=0 gives t unchanged; no shift by OUT_W.
//   RS: out_data = (x1 >> amt)[OUT_W-1:0].
//   TRUNC: out_data = x1[STATE_W-1 -: OUT_W].
//  Advance: adv2 = !out_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1 (registered-state function only).
//  Stage 1 loads when adv1. Stage 2 loads s1 contents when adv2. A bubble clears the valid bit.
//  Latency: 2 cycles from input transfer to out_valid when unstalled. Full throughput is 1 word/cycle.
//  Pipeline full (both valid, out_ready=0): in_ready=0 and no data is lost.
//  Accept-and-drain in same cycle: stage 1 takes the new word while stage 2 takes the old stage 1 word.
//  out_count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0. flush does not clear it.
//  flush=1: s1_valid, out_valid cleared next edge. Input presented that cycle is dropped; in_ready forced 0 during flush.
//   Any output transfer in the flush cycle still counts.
//  Reset mid-operation: all in-flight words discarded immediately (async). No output after release until new input.
// TESTING
//  1. RR, in_state=64'h8000_0000_0000_0000, out_ready=1 -> out_valid 2 cycles later, out_data=32'h0000_0004.
//  2. RS same state -> 32'h0000_8000. TRUNC same state -> 32'h8000_0000. RR 64'h0000_0000_FFFF_FFFF -> 32'h0000_001F.
//  3. Stream 100 random states with random modes and random out_ready: outputs match the reference model in order.
//     Check no drops/duplicates, out_data stable while stalled, in_ready=0 only when both stages full.
//  4. out_ready=0 for 10 cycles with in_valid=1 -> exactly 2 words accepted, then in_ready=0.
//     Release -> 2 words drain, then 1 word/cycle.
//  5. flush with both stages full -> out_valid=0 next cycle, out_count unchanged. Wrap test with CNT_W=4: 17 transfers -> out_count=1.
//  6. Assert rst low mid-stream -> out_valid/out_data/out_count=0 without clock edge. First output after release is 2 cycles after the first new input.

Source files
------------

// File: rtl/pcg_permute_pipe.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pcg_permute_pipe
//   PCG output-permutation stage. Turns a STATE_W-bit LCG/MCG state into an
//   OUT_W-bit random word using a run-time selected permutation:
//   XSH-RR, XSH-RS or plain truncation. Two register stages with valid/ready
//   handshaking on both sides, plus a wrapping count of output transfers.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   flush      synchronous clear of both pipeline stages
//   in_valid   state word valid
//   in_ready   stage accepts a state word this cycle
//   in_state   generator state (STATE_W)
//   in_mode    00 XSH-RR, 01 XSH-RS, 10 TRUNC, 11 reserved (TRUNC)
//   out_valid  permuted word valid
//   out_ready  downstream accepts the word
//   out_data   permuted word (OUT_W)
//   out_count  completed output transfers, wraps (CNT_W)
// ---------------------------------------------------------------------------
module pcg_permute_pipe #(
    parameter int STATE_W = 64,
    parameter int OUT_W   = 32,
    parameter int ROT_W   = 5,
    parameter int RR_XS   = 18,
    parameter int RS_OPW  = 3,
    parameter int RS_XS   = 22,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [CNT_W-1:0]   out_count
);

    typedef enum logic [1:0] {
        PERM_RR    = 2'b00,
        PERM_RS    = 2'b01,
        PERM_TRUNC = 2'b10
    } perm_e;

    // Holds any shift amount below STATE_W (XSH-RS shifts reach RS_XS + 2^RS_OPW - 1).
    localparam int AMT_W = $clog2(STATE_W);
    // XSH-RR keeps the OUT_W bits just below the ROT_W rotate-select bits.
    localparam int RR_SH = STATE_W - OUT_W - ROT_W;

    // Stage 1 registers: xorshifted state, shift/rotate amount, permutation.
    logic               s1_valid_q, s1_valid_d;
    logic [STATE_W-1:0] s1_x_q,     s1_x_d;
    logic [AMT_W-1:0]   s1_amt_q,   s1_amt_d;
    perm_e              s1_perm_q,  s1_perm_d;

    // Stage 2 (output) registers.
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q,  out_data_d;
    logic [CNT_W-1:0]   count_q,     count_d;

    logic adv1, adv2, in_xfer, out_xfer;

    // Handshake: advance decisions depend only on registered valids, out_ready
    // and flush, so there is no path from in_valid to out_valid.
    assign adv2     = !out_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1 && !flush;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    // Stage 1 datapath: xorshift and amount selection from the raw state.
    perm_e              in_perm;
    logic [STATE_W-1:0] in_x;
    logic [AMT_W-1:0]   in_amt;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        in_perm = PERM_TRUNC;
        in_x    = in_state;
        in_amt  = '0;
        case (in_mode)
            2'b00: begin
                in_perm = PERM_RR;
                in_x    = in_state ^ (in_state >> RR_XS);
                in_amt  = AMT_W'(in_state[STATE_W-1 -: ROT_W]);
            end
            2'b01: begin
                in_perm = PERM_RS;
                in_x    = in_state ^ (in_state >> RS_XS);
                in_amt  = AMT_W'(RS_XS) + AMT_W'(in_state[STATE_W-1 -: RS_OPW]);
            end
            default: ; // 10 and reserved 11 both truncate
        endcase
    end

    // Stage 2 datapath: final shift / rotate of the stage-1 word.
    logic [OUT_W-1:0] rr_t;
    logic [OUT_W-1:0] s2_word;

    always_comb begin
        rr_t    = OUT_W'(s1_x_q >> RR_SH);
        s2_word = s1_x_q[STATE_W-1 -: OUT_W];
        case (s1_perm_q)
            // Rotating the doubled word right never shifts by OUT_W, so a
            // rotate amount of 0 returns rr_t unchanged.
            PERM_RR: s2_word = OUT_W'({rr_t, rr_t} >> s1_amt_q[ROT_W-1:0]);
            PERM_RS: s2_word = OUT_W'(s1_x_q >> s1_amt_q);
            default: ;
        endcase
    end

    // Next-state logic for both stages and the transfer counter.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_x_d      = s1_x_q;
        s1_amt_d    = s1_amt_q;
        s1_perm_d   = s1_perm_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        count_d     = count_q;

        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            // A bubble (no input transfer) only clears the valid bit.
            if (adv1) begin
                s1_valid_d = in_xfer;
            end
            if (in_xfer) begin
                s1_x_d    = in_x;
                s1_amt_d  = in_amt;
                s1_perm_d = in_perm;
            end
            if (adv2) begin
                out_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    out_data_d = s2_word;
                end
            end
        end

        // Transfers in a flush cycle still complete and still count.
        if (out_xfer) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: the datapath registers are reset along with the valids so that
    // out_data reads zero after reset, not stale data from before it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_amt_q    <= '0;
            s1_perm_q   <= PERM_RR;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            count_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_amt_q    <= s1_amt_d;
            s1_perm_q   <= s1_perm_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = count_q;

endmodule
